// File: rtl/fetch_unit.sv
// Program counter / fetch stage with IDLE -> RUN -> HALTED sequencing and a RUN-cycle counter.
// Latency: next PC, state and cycle count are all registered; one clock from inputs to outputs.
// No backpressure: the decoder enables are sampled every RUN cycle and never stalled.
//
// Ports:
//   CLK, Reset         clock and synchronous active-high reset (reset beats every other input)
//   Start              enters RUN from IDLE or HALTED, loading START_PC and clearing CycleCt
//   Halt               stops fetch; PC holds, enables are ignored on that cycle
//   jump_en, JmpSel    absolute jump to the constant target table entry JmpSel
//   branch_en,BrOffset PC-relative branch by a signed offset (jump has priority)
//   ProgCtr            current PC, instruction ROM address
//   Running, Done      state decodes for RUN and HALTED
//   CycleCt            saturating count of RUN cycles since the last Start
module fetch_unit #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned OFF_W     = 6,
  parameter int unsigned LUT_SEL_W = 3,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Halt,
  input  logic                 jump_en,
  input  logic                 branch_en,
  input  logic [LUT_SEL_W-1:0] JmpSel,
  input  logic [OFF_W-1:0]     BrOffset,
  output logic [PC_W-1:0]      ProgCtr,
  output logic                 Running,
  output logic                 Done,
  output logic [CNT_W-1:0]     CycleCt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int unsigned LUT_N = 2 ** LUT_SEL_W;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Jump target table: entry k sits at 16*k, truncated to the PC width.
  logic [PC_W-1:0] jump_lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign jump_lut[k] = PC_W'(16 * k);
  end

  // Offset is sign-extended to PC width so the add wraps modulo 2**PC_W.
  logic [PC_W-1:0] br_off_sext;
  assign br_off_sext = {{(PC_W - OFF_W){BrOffset[OFF_W-1]}}, BrOffset};

  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_branch;
  assign pc_seq    = pc_q + PC_W'(1);
  assign pc_branch = pc_q + br_off_sext;

  // Counter stops at all-ones rather than wrapping.
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // The decoder enables are only looked at inside the RUN arm, so unknown
  // values on them while idle or halted cannot reach the state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (Halt) begin
          state_d = HALTED;
        end else if (jump_en) begin
          pc_d = jump_lut[JmpSel];
        end else if (branch_en) begin
          pc_d = pc_branch;
        end else begin
          pc_d = pc_seq;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
        cnt_d   = '0;
      end
    endcase
  end

  assign ProgCtr = pc_q;
  assign CycleCt = cnt_q;
  assign Running = (state_q == RUN);
  assign Done    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, next-PC priority, wrap, halt/restart,
// reset mid-run, and counter saturation on a narrow-counter second instance.
// Inputs change 1ns after the rising edge; outputs are checked at that point too.
module tb_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic        Start;
  logic        Halt;
  logic        jump_en;
  logic        branch_en;
  logic [2:0]  JmpSel;
  logic [5:0]  BrOffset;
  logic [9:0]  ProgCtr;
  logic        Running;
  logic        Done;
  logic [15:0] CycleCt;

  logic [9:0]  s_pc;
  logic        s_run;
  logic        s_done;
  logic [2:0]  s_cyc;

  int n_chk;
  int n_fail;
  int exp_cyc;

  fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt),
    .jump_en(jump_en), .branch_en(branch_en), .JmpSel(JmpSel), .BrOffset(BrOffset),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .CycleCt(CycleCt)
  );

  fetch_unit #(.CNT_W(3)) dut_sat (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt),
    .jump_en(jump_en), .branch_en(branch_en), .JmpSel(JmpSel), .BrOffset(BrOffset),
    .ProgCtr(s_pc), .Running(s_run), .Done(s_done), .CycleCt(s_cyc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation budget exceeded");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One clock spent in RUN: the model counter advances with it.
  task automatic run_tick(input logic j, input logic b, input logic [2:0] sel,
                          input logic [5:0] off);
    jump_en   = j;
    branch_en = b;
    JmpSel    = sel;
    BrOffset  = off;
    tick();
    exp_cyc++;
    jump_en   = 1'b0;
    branch_en = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    exp_cyc   = 0;
    Reset     = 1'b1;
    Start     = 1'b0;
    Halt      = 1'b0;
    jump_en   = 1'b0;
    branch_en = 1'b0;
    JmpSel    = 3'd0;
    BrOffset  = 6'd0;
    tick();
    tick();
    chk("rst_pc",   32'(ProgCtr), 32'h000);
    chk("rst_run",  32'(Running), 0);
    chk("rst_done", 32'(Done),    0);
    chk("rst_cyc",  32'(CycleCt), 0);

    // Unknown enables while idle must not move anything.
    Reset     = 1'b0;
    jump_en   = 1'bx;
    branch_en = 1'bx;
    tick();
    tick();
    chk("idle_x_pc",  32'(ProgCtr), 32'h000);
    chk("idle_x_run", 32'(Running), 0);
    jump_en   = 1'b0;
    branch_en = 1'b0;

    // Start pulse, then five sequential fetches.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_run", 32'(Running), 1);
    chk("start_pc",  32'(ProgCtr), 32'h000);
    chk("start_cyc", 32'(CycleCt), 0);
    for (int i = 1; i <= 5; i++) begin
      run_tick(1'b0, 1'b0, 3'd0, 6'd0);
      chk("seq_pc", 32'(ProgCtr), 32'(i));
    end
    chk("seq_cyc", 32'(CycleCt), 5);
    chk("seq_run", 32'(Running), 1);

    // Jump beats branch.
    run_tick(1'b0, 1'b1, 3'd0, 6'd3);
    chk("br_to_8", 32'(ProgCtr), 32'h008);
    run_tick(1'b1, 1'b1, 3'd3, 6'd5);
    chk("jmp_wins", 32'(ProgCtr), 32'h030);

    // Negative branch and wrap in both directions.
    run_tick(1'b1, 1'b0, 3'd2, 6'd0);
    chk("jmp_20", 32'(ProgCtr), 32'h020);
    run_tick(1'b0, 1'b1, 3'd0, 6'b111100);
    chk("br_m4", 32'(ProgCtr), 32'h01C);
    run_tick(1'b1, 1'b0, 3'd0, 6'd0);
    chk("jmp_0", 32'(ProgCtr), 32'h000);
    run_tick(1'b0, 1'b1, 3'd0, 6'b111110);
    chk("br_wrap_neg", 32'(ProgCtr), 32'h3FE);
    run_tick(1'b0, 1'b1, 3'd0, 6'd4);
    chk("br_wrap_pos", 32'(ProgCtr), 32'h002);
    run_tick(1'b0, 1'b1, 3'd0, 6'b111101);
    chk("br_to_3ff", 32'(ProgCtr), 32'h3FF);
    run_tick(1'b0, 1'b0, 3'd0, 6'd0);
    chk("inc_wrap", 32'(ProgCtr), 32'h000);
    chk("inc_wrap_run", 32'(Running), 1);
    chk("cyc_mid", 32'(CycleCt), 32'(exp_cyc));

    // Halt with a jump pending: PC holds, counter includes the halt cycle.
    run_tick(1'b1, 1'b0, 3'd1, 6'd0);
    chk("jmp_10", 32'(ProgCtr), 32'h010);
    run_tick(1'b0, 1'b0, 3'd0, 6'd0);
    run_tick(1'b0, 1'b0, 3'd0, 6'd0);
    chk("pc_12", 32'(ProgCtr), 32'h012);
    Halt = 1'b1;
    run_tick(1'b1, 1'b0, 3'd7, 6'd0);
    Halt = 1'b0;
    chk("halt_done", 32'(Done),    1);
    chk("halt_run",  32'(Running), 0);
    chk("halt_pc",   32'(ProgCtr), 32'h012);
    chk("halt_cyc",  32'(CycleCt), 32'(exp_cyc));
    jump_en   = 1'bx;
    branch_en = 1'bx;
    tick();
    tick();
    jump_en   = 1'b0;
    branch_en = 1'b0;
    chk("halted_pc",   32'(ProgCtr), 32'h012);
    chk("halted_cyc",  32'(CycleCt), 32'(exp_cyc));
    chk("halted_done", 32'(Done),    1);

    // Restart from HALTED.
    Start = 1'b1;
    tick();
    Start   = 1'b0;
    exp_cyc = 0;
    chk("restart_pc",   32'(ProgCtr), 32'h000);
    chk("restart_cyc",  32'(CycleCt), 0);
    chk("restart_run",  32'(Running), 1);
    chk("restart_done", 32'(Done),    0);

    // Reset mid-run with a jump pending.
    run_tick(1'b1, 1'b0, 3'd5, 6'd0);
    chk("jmp_50", 32'(ProgCtr), 32'h050);
    run_tick(1'b0, 1'b1, 3'd0, 6'd5);
    chk("pc_55", 32'(ProgCtr), 32'h055);
    Reset   = 1'b1;
    jump_en = 1'b1;
    JmpSel  = 3'd7;
    tick();
    jump_en = 1'b0;
    chk("midrst_pc",   32'(ProgCtr), 32'h000);
    chk("midrst_run",  32'(Running), 0);
    chk("midrst_done", 32'(Done),    0);
    chk("midrst_cyc",  32'(CycleCt), 0);
    Start = 1'b1;
    tick();
    chk("rst_beats_start", 32'(Running), 0);
    Reset = 1'b0;
    tick();
    Start   = 1'b0;
    exp_cyc = 0;
    chk("start_after_rst", 32'(Running), 1);
    chk("start_after_rst_pc", 32'(ProgCtr), 32'h000);

    // Saturation on the 3-bit counter copy; the 16-bit one keeps counting.
    for (int i = 0; i < 7; i++) begin
      run_tick(1'b0, 1'b0, 3'd0, 6'd0);
    end
    chk("sat_reach", 32'(s_cyc), 7);
    run_tick(1'b0, 1'b0, 3'd0, 6'd0);
    run_tick(1'b0, 1'b0, 3'd0, 6'd0);
    chk("sat_hold",  32'(s_cyc),   7);
    chk("wide_cyc",  32'(CycleCt), 9);
    chk("sat_pc",    32'(s_pc),    32'h009);
    chk("sat_run",   32'(s_run),   1);
    chk("sat_done",  32'(s_done),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
